// File: rtl/mqnic_tx_doorbell_pkg.sv
// Shared types for the TX doorbell dedup block: FSM states, queue index type,
// bypass flags and pending-bit forward selects.
package mqnic_tx_doorbell_pkg;

    localparam int DEFAULT_QUEUE_INDEX_WIDTH = 13;

    typedef logic [DEFAULT_QUEUE_INDEX_WIDTH-1:0] queue_idx_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic BYPASS_OFF = 1'b0;
    localparam logic BYPASS_ON  = 1'b1;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_SET  = 2'd1,
        FWD_CLR  = 2'd2,
        FWD_POP  = 2'd3
    } fwd_sel_e;

    function automatic logic apply_forward(input fwd_sel_e sel, input logic ram_bit);
        logic res;
        case (sel)
            FWD_SET:          res = 1'b1;
            FWD_CLR, FWD_POP: res = 1'b0;
            FWD_NONE:         res = ram_bit;
            default:          res = ram_bit;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mqnic_tx_doorbell_dedup_if.sv
// Doorbell stream interface (queue index + valid/ready).
interface mqnic_tx_doorbell_dedup_if
    import mqnic_tx_doorbell_pkg::*;
#(
    parameter int QUEUE_INDEX_WIDTH = DEFAULT_QUEUE_INDEX_WIDTH
);
    logic [QUEUE_INDEX_WIDTH-1:0] queue;
    logic                         valid;
    logic                         ready;

    modport master (output queue, output valid, input ready);
    modport slave  (input queue, input valid, output ready);
endinterface

// File: rtl/mqnic_tx_doorbell_fifo.sv
// Synchronous doorbell FIFO; the head is a registered copy of the oldest entry,
// and a push is accepted while full when a pop happens in the same cycle.
module mqnic_tx_doorbell_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(1'b0);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_next_s;
    logic [AW:0]      count_q, count_d;
    logic             head_valid_q, present_s;
    logic [WIDTH-1:0] head_data_q;

    // Next read pointer, occupancy and whether a head remains after this cycle's pop
    always_comb begin
        rd_next_s = pop_i ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        present_s = (count_q != (pop_i ? CNT_ONE : CNT_ZERO));
        count_d   = count_q + (push_i ? CNT_ONE : CNT_ZERO) - (pop_i ? CNT_ONE : CNT_ZERO);
    end

    // Storage array; never reset
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            rd_ptr_q     <= rd_next_s;
            count_q      <= count_d;
            head_valid_q <= present_s;
            if (present_s) begin
                head_data_q <= mem_q[rd_next_s];
            end
        end
    end

    assign head_data_o = head_data_q;
    assign full_o      = (count_q == CNT_DEPTH);
    assign empty_o     = !head_valid_q;

endmodule

// File: rtl/mqnic_tx_doorbell_dedup.sv
// TX doorbell deduplicator: per-queue pending bitmap in front of a doorbell FIFO.
// Optional statistics counters are built when MQNIC_TX_DOORBELL_STATS_EN is defined.
module mqnic_tx_doorbell_dedup
    import mqnic_tx_doorbell_pkg::*;
#(
    parameter int QUEUE_INDEX_WIDTH = DEFAULT_QUEUE_INDEX_WIDTH,
    parameter int FIFO_DEPTH        = 1024,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    mqnic_tx_doorbell_dedup_if.slave  s_axis_doorbell,
    mqnic_tx_doorbell_dedup_if.master m_axis_doorbell,
    output logic                      init_done,
    output logic                      overflow,
    output logic [CNT_WIDTH-1:0]      stat_coalesced,
    output logic [CNT_WIDTH-1:0]      stat_accepted
);
    localparam int QW = QUEUE_INDEX_WIDTH;
    localparam int NQ = 2**QW;
    typedef logic [QW-1:0] qidx_t;
    localparam qidx_t QIDX_ONE  = QW'(1'b1);
    localparam qidx_t QIDX_LAST = {QW{1'b1}};

    state_e   state_q, state_d;
    qidx_t    sweep_ptr_q, sweep_ptr_d;
    logic     bitmap_q [NQ];

    logic     s1_valid_q, s1_bypass_q;
    qidx_t    s1_queue_q;
    logic     s2_valid_q, s2_bypass_q, s2_rd_q;
    qidx_t    s2_queue_q;
    logic     set_fwd_q, clr_fwd_q;
    qidx_t    set_fwd_queue_q, clr_fwd_queue_q;
    logic     overflow_q;

    fwd_sel_e fwd_sel_s;
    logic     pending_s, push_s, set_s, clr_s, full_drop_s;
    logic     pop_s, can_push_s, fifo_full_s, fifo_empty_s;
    qidx_t    head_queue_s;

    // FSM state and sweep pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            sweep_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
        end
    end

    // INIT walks every bitmap entry once, then RUN forever
    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        case (state_q)
            ST_INIT: begin
                sweep_ptr_d = sweep_ptr_q + QIDX_ONE;
                if (sweep_ptr_q == QIDX_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // S1/S2 pipeline registers and last-cycle write history for forwarding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q      <= 1'b0;
            s1_bypass_q     <= BYPASS_OFF;
            s1_queue_q      <= '0;
            s2_valid_q      <= 1'b0;
            s2_bypass_q     <= BYPASS_OFF;
            s2_queue_q      <= '0;
            set_fwd_q       <= 1'b0;
            set_fwd_queue_q <= '0;
            clr_fwd_q       <= 1'b0;
            clr_fwd_queue_q <= '0;
            overflow_q      <= 1'b0;
        end else begin
            s1_valid_q      <= s_axis_doorbell.valid;
            s1_bypass_q     <= (state_q == ST_INIT) ? BYPASS_ON : BYPASS_OFF;
            s1_queue_q      <= s_axis_doorbell.queue;
            s2_valid_q      <= s1_valid_q;
            s2_bypass_q     <= s1_bypass_q;
            s2_queue_q      <= s1_queue_q;
            set_fwd_q       <= set_s;
            set_fwd_queue_q <= s2_queue_q;
            clr_fwd_q       <= clr_s;
            clr_fwd_queue_q <= head_queue_s;
            overflow_q      <= overflow_q | full_drop_s;
        end
    end

    // Synchronous bitmap read issued from S1
    always_ff @(posedge clk) begin
        s2_rd_q <= bitmap_q[s1_queue_q];
    end

    // Bitmap writes: sweep owns the port in INIT; in RUN the set is applied after the clear so it wins
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            bitmap_q[sweep_ptr_q] <= 1'b0;
        end else begin
            if (clr_s) begin
                bitmap_q[head_queue_s] <= 1'b0;
            end
            if (set_s) begin
                bitmap_q[s2_queue_q] <= 1'b1;
            end
        end
    end

    // S2 decision on the forwarded pending bit
    always_comb begin
        fwd_sel_s = FWD_NONE;
        if (pop_s && (head_queue_s == s2_queue_q)) begin
            fwd_sel_s = FWD_POP;
        end else if (set_fwd_q && (set_fwd_queue_q == s2_queue_q)) begin
            fwd_sel_s = FWD_SET;
        end else if (clr_fwd_q && (clr_fwd_queue_q == s2_queue_q)) begin
            fwd_sel_s = FWD_CLR;
        end else begin
            fwd_sel_s = FWD_NONE;
        end
        pending_s   = apply_forward(fwd_sel_s, s2_rd_q) && (s2_bypass_q == BYPASS_OFF);
        push_s      = s2_valid_q && !pending_s && can_push_s;
        set_s       = push_s && (s2_bypass_q == BYPASS_OFF);
        full_drop_s = s2_valid_q && !pending_s && !can_push_s;
        clr_s       = pop_s && (state_q == ST_RUN);
    end

    assign pop_s      = !fifo_empty_s && m_axis_doorbell.ready;
    assign can_push_s = !fifo_full_s || pop_s;

    mqnic_tx_doorbell_fifo #(
        .WIDTH (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (s2_queue_q),
        .pop_i       (pop_s),
        .head_data_o (head_queue_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    assign s_axis_doorbell.ready = 1'b1;
    assign m_axis_doorbell.valid = !fifo_empty_s;
    assign m_axis_doorbell.queue = head_queue_s;
    assign init_done             = (state_q == ST_RUN);
    assign overflow              = overflow_q;

`ifdef MQNIC_TX_DOORBELL_STATS_EN
    localparam logic [CNT_WIDTH-1:0] STAT_ONE = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] STAT_MAX = {CNT_WIDTH{1'b1}};

    logic                 dup_s;
    logic [CNT_WIDTH-1:0] coalesced_q, accepted_q;

    assign dup_s = s2_valid_q && pending_s;

    // Saturating statistics counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coalesced_q <= '0;
            accepted_q  <= '0;
        end else begin
            if (dup_s && (coalesced_q != STAT_MAX)) begin
                coalesced_q <= coalesced_q + STAT_ONE;
            end
            if (push_s && (accepted_q != STAT_MAX)) begin
                accepted_q <= accepted_q + STAT_ONE;
            end
        end
    end

    assign stat_coalesced = coalesced_q;
    assign stat_accepted  = accepted_q;
`else
    assign stat_coalesced = {CNT_WIDTH{1'b0}};
    assign stat_accepted  = {CNT_WIDTH{1'b0}};
`endif

endmodule
